// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: segment bit order, blank/dash codes
// and the active-low digit-to-segment table.
package bcd_disp_pkg;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by digit value.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic is_valid_bcd(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bundle between the counter chain / control side and the display scanner.
interface bcd_display_scanner_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] digits_in;
    logic              blank_lz;
    logic [NDIG-1:0]   blink_mask;
    logic              colon_en;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [NDIG-1:0]   an_n;
    logic              frame_start;

    modport master (
        output digits_in, blank_lz, blink_mask, colon_en,
        input  seg_n, dp_n, an_n, frame_start
    );

    modport slave (
        input  digits_in, blank_lz, blink_mask, colon_en,
        output seg_n, dp_n, an_n, frame_start
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        if (is_valid_bcd(bcd)) begin
            seg_n = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode display driver: per-frame digit snapshot, one digit
// per slot, leading-zero blanking, edit blinking, colon point and anode dead time.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int DP_POS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_display_scanner_if.slave  bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0] DP_IDX    = IDX_W'(DP_POS);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_digits_q, shadow_digits_d;
    logic [NDIG-1:0]   shadow_mask_q, shadow_mask_d;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              blink_q, blink_d;
    logic              frame_start_q, frame_start_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic              dp_n_q, dp_n_d;
    logic [NDIG-1:0]   an_n_q, an_n_d;

    logic              tick;
    logic              frame_end;
    logic [3:0]        sh_dig [NDIG];
    logic [NDIG-1:0]   zero_from;
    logic [3:0]        cur_digit;
    logic [6:0]        dec_seg;
    logic              lz_blank;
    logic              blink_blank;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_unpack
        assign sh_dig[gi] = shadow_digits_q[4*gi +: 4];
    end

    // zero_from[i]: every shadow digit from i up to the most significant is zero.
    always_comb begin
        zero_from = '0;
        zero_from[NDIG-1] = (sh_dig[NDIG-1] == 4'd0);
        for (int i = NDIG - 2; i >= 0; i--) begin
            zero_from[i] = (sh_dig[i] == 4'd0) && zero_from[i+1];
        end
    end

    assign cur_digit   = sh_dig[idx_q];
    assign lz_blank    = bus.blank_lz && (idx_q != '0) && zero_from[idx_q];
    assign blink_blank = blink_q && shadow_mask_q[idx_q];
    assign tick        = (cnt_q == CNT_LAST);
    assign frame_end   = tick && (idx_q == IDX_LAST);

    bcd_to_seg u_dec (
        .bcd   (cur_digit),
        .seg_n (dec_seg)
    );

    always_comb begin
        cnt_d           = tick ? '0 : cnt_q + 1'b1;
        idx_d           = idx_q;
        shadow_digits_d = shadow_digits_q;
        shadow_mask_d   = shadow_mask_q;
        frame_cnt_d     = frame_cnt_q;
        blink_d         = blink_q;
        frame_start_d   = frame_end;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (frame_end) begin
            shadow_digits_d = bus.digits_in;
            shadow_mask_d   = bus.blink_mask;
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // Dead time at slot start keeps the previous digit from ghosting into this one.
        seg_n_d = SEG_BLANK;
        dp_n_d  = 1'b1;
        an_n_d  = '1;
        if ((cnt_q >= GUARD_CNT) && !lz_blank && !blink_blank) begin
            an_n_d  = ~(NDIG'(1) << idx_q);
            seg_n_d = dec_seg;
            dp_n_d  = !((idx_q == DP_IDX) && bus.colon_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            shadow_digits_q <= '0;
            shadow_mask_q   <= '0;
            frame_cnt_q     <= '0;
            blink_q         <= 1'b0;
            frame_start_q   <= 1'b0;
            seg_n_q         <= SEG_BLANK;
            dp_n_q          <= 1'b1;
            an_n_q          <= '1;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_mask_q   <= shadow_mask_d;
            frame_cnt_q     <= frame_cnt_d;
            blink_q         <= blink_d;
            frame_start_q   <= frame_start_d;
            seg_n_q         <= seg_n_d;
            dp_n_q          <= dp_n_d;
            an_n_q          <= an_n_d;
        end
    end

    assign bus.seg_n       = seg_n_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.an_n        = an_n_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Reader side of the BCD digit counter chain. It takes the packed BCD digits written by the per-digit adder/subtractor stages and drives a time-multiplexed, common-anode 7-segment display.
- Snapshots the digits once per frame so the display never tears, then scans one digit per slot.
- Applies leading-zero blanking, edit-mode blinking, a colon point and anti-ghosting dead time.

Parameters:
- NDIG, 4, number of digits scanned (digit 0 = least significant, digits_in[3:0]).
- SCAN_DIV, 50000, clock cycles per digit slot; must be at least 2.
- GUARD, 2, dead-time cycles at the start of each slot with all anodes off; must be less than SCAN_DIV.
- BLINK_FRAMES, 64, frames per blink half-period; must be at least 1.
- DP_POS, 2, digit index whose decimal point acts as the colon.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- digits_in  in  4*NDIG  packed BCD digits from the counter chain.
- blank_lz  in  1  1 = blank leading zeros.
- blink_mask  in  NDIG  1 = digit blinks (edit mode).
- colon_en  in  1  1 = light the dp of digit DP_POS.
- seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- an_n  out  NDIG  active-low anode enables, one-hot-low or all high.
- frame_start  out  1  one-cycle pulse when a new frame begins.

Behaviour:
- Reset (async, immediate, also mid-frame):
  - Outputs: an_n all 1, seg_n=7'h7F, dp_n=1, frame_start=0.
  - Internal state: cnt=0, idx=0, shadow digits=0, shadow mask=0, frame counter=0, blink phase=0.
- Prescaler: cnt counts 0..SCAN_DIV-1. tick = (cnt==SCAN_DIV-1).
- On tick:
  - cnt goes to 0.
  - idx goes to idx+1, wrapping from NDIG-1 to 0.
- Frame boundary = tick while idx==NDIG-1. At a frame boundary:
  - shadow loads digits_in and blink_mask.
  - The frame counter increments. On reaching BLINK_FRAMES it clears and the blink phase toggles.
  - frame_start is registered high for exactly the next cycle (the cycle with idx=0, cnt=0).
- After reset the shadow holds 0 until the first frame boundary, NDIG*SCAN_DIV cycles later.
- Decode (combinational from shadow[idx], active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Values 10..15 are invalid and show a dash, 3F.
- Leading-zero blank:
  - Applies only when blank_lz=1.
  - Digit i (i>=1) is blanked if shadow digits i..NDIG-1 are all zero.
  - Digit 0 is never blanked.
  - An invalid code counts as nonzero.
- Blink blank: digit i is blanked when the blink phase is 1 and shadow mask bit i is 1.
- Slot output:
  - During cnt<GUARD: an_n all 1, seg_n=7F, dp_n=1.
  - Otherwise, if the digit is blanked: an_n all 1, seg_n=7F, dp_n=1.
  - Otherwise: an_n has bit idx low, seg_n is the decoded value, dp_n=0 only when idx==DP_POS and colon_en=1.
  - colon_en is used live, not snapshotted.
- Latency: seg_n, dp_n and an_n are registered, so each reflects the cnt/idx/shadow state of the previous cycle.
- Never more than one anode is low at a time. Segments never change while an anode is enabled within a slot.
- digits_in and blink_mask changes mid-frame have no visible effect until the next frame boundary.

Decomposition:
- Package bcd_disp_pkg holds:
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - the digit-to-segment table for 0..9;
  - the segment bit-order definition.
- One sub-module, bcd_to_seg: combinational 4-bit BCD to 7-bit active-low segment decoder, including the dash for invalid codes.

Test Plan:
All scenarios use NDIG=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2, DP_POS=2.
- Reset: assert rst mid-slot with an_n=1110 -> an_n=1111, seg_n=7F, dp_n=1, frame_start=0 immediately. After release, first frame_start at cycle 16.
- Scan: digits_in=16'h1234 from reset, observed after the first frame_start:
  - slot 0: seg_n=19 with an_n=1110;
  - slot 1: seg_n=30 with an_n=1101;
  - slot 2: seg_n=24 with an_n=1011;
  - slot 3: seg_n=79 with an_n=0111;
  - first slot cycle blank (guard) plus 1-cycle output latency.
- Anti-tear: change digits_in to 16'h9999 in the middle of slot 1 -> rest of frame still shows 1234. Next frame shows seg_n=10 on all digits.
- Leading zeros and invalid code:
  - digits_in=16'h0050, blank_lz=1 -> digits 3 and 2 keep an_n high for their whole slots; digit 1 shows 12; digit 0 shows 40.
  - digits_in=16'h00A0 -> digit 1 shows 3F and is not blanked.
- Blink and colon: blink_mask=4'b0001, colon_en=1, digits 1234:
  - digit 0 is shown for 2 frames, then blanked for 2 frames, repeating;
  - dp_n=0 only during digit 2's active cycles.
